// File: rtl/pc_gen_bp_pkg.sv
// Shared types and constants for the branch-predicting PC generator.
//   fsm_state_e : fetch FSM states (BOOT, RUN, FLUSH)
//   CTR_*       : 2-bit saturating counter encodings
//   ctr_next    : saturating counter step toward the resolved direction
package pc_gen_bp_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fsm_state_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Saturating increment on taken, saturating decrement on not-taken.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end else begin
            res = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pc_gen_bp_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
//   clk, rst        : clock, async active-low reset (clears all entries)
//   lookup_pc_i     : PC to predict for (combinational lookup)
//   pred_taken_o    : hit with counter in a taken state
//   pred_target_o   : stored target when predicted taken, else 0
//   upd_valid_i     : apply a branch resolution at the next edge
//   upd_pc_i        : PC of the resolved branch
//   upd_taken_i     : resolved direction
//   upd_target_i    : resolved target
module pc_btb
    import pc_gen_bp_pkg::*;
#(
    parameter int unsigned LEN        = 32,
    parameter int unsigned BTB_DEPTH  = 16,
    parameter int unsigned INST_BYTES = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [LEN-1:0] lookup_pc_i,
    output logic           pred_taken_o,
    output logic [LEN-1:0] pred_target_o,
    input  logic           upd_valid_i,
    input  logic [LEN-1:0] upd_pc_i,
    input  logic           upd_taken_i,
    input  logic [LEN-1:0] upd_target_i
);

    localparam int unsigned IB = $clog2(INST_BYTES);
    localparam int unsigned XB = $clog2(BTB_DEPTH);
    localparam int unsigned TW = LEN - IB - XB;

    logic           valid_q  [BTB_DEPTH];
    logic [TW-1:0]  tag_q    [BTB_DEPTH];
    logic [LEN-1:0] target_q [BTB_DEPTH];
    logic [1:0]     ctr_q    [BTB_DEPTH];

    logic [XB-1:0] lk_idx;
    logic [TW-1:0] lk_tag;
    logic          lk_hit;
    logic [XB-1:0] up_idx;
    logic [TW-1:0] up_tag;
    logic          up_hit;

    // Instruction-alignment bits never take part in indexing or tagging.
    if (IB > 0) begin : g_lsb
        logic unused_lsb;
        assign unused_lsb = ^{lookup_pc_i[IB-1:0], upd_pc_i[IB-1:0]};
    end

    // Lookup reads registered storage only, so a same-cycle update is not visible.
    always_comb begin
        lk_idx        = lookup_pc_i[IB+XB-1:IB];
        lk_tag        = lookup_pc_i[LEN-1:IB+XB];
        lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken_o  = lk_hit && ctr_q[lk_idx][1];
        pred_target_o = pred_taken_o ? target_q[lk_idx] : '0;
    end

    always_comb begin
        up_idx = upd_pc_i[IB+XB-1:IB];
        up_tag = upd_pc_i[LEN-1:IB+XB];
        up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    end

    // Hit trains the counter; taken miss allocates over whatever was there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(BTB_DEPTH); i++) begin
                valid_q[i]  <= FALSE;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (upd_valid_i) begin
            if (up_hit) begin
                ctr_q[up_idx] <= ctr_next(ctr_q[up_idx], upd_taken_i);
                if (upd_taken_i) begin
                    target_q[up_idx] <= upd_target_i;
                end
            end else if (upd_taken_i) begin
                valid_q[up_idx]  <= TRUE;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target_i;
                ctr_q[up_idx]    <= CTR_WT;
            end
        end
    end

endmodule

// File: rtl/pc_gen_bp.sv
// Fetch PC generator with BTB prediction and prioritised redirects.
//   clk, rst           : clock, async active-low reset
//   rdy_in             : global enable; low freezes PC, FSM and BTB
//   redirect_valid/pc  : redirect channels, channel 0 highest priority
//   fetch_valid/ready  : handshake offering fetch_pc to IF
//   fetch_pc           : current fetch PC
//   fetch_pred_taken   : BTB predicts taken for fetch_pc
//   fetch_pred_target  : predicted target, 0 when not taken
//   upd_*              : branch resolution used to train the BTB
module pc_gen_bp
    import pc_gen_bp_pkg::*;
#(
    parameter int unsigned    LEN          = 32,
    parameter logic [LEN-1:0] RESET_PC     = '0,
    parameter int unsigned    INST_BYTES   = 4,
    parameter int unsigned    BTB_DEPTH    = 16,
    parameter int unsigned    NUM_REDIRECT = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy_in,
    input  logic [NUM_REDIRECT-1:0]     redirect_valid,
    input  logic [NUM_REDIRECT*LEN-1:0] redirect_pc,
    output logic                        fetch_valid,
    input  logic                        fetch_ready,
    output logic [LEN-1:0]              fetch_pc,
    output logic                        fetch_pred_taken,
    output logic [LEN-1:0]              fetch_pred_target,
    input  logic                        upd_valid,
    input  logic [LEN-1:0]              upd_pc,
    input  logic                        upd_taken,
    input  logic [LEN-1:0]              upd_target
);

    fsm_state_e     state_q;
    logic [LEN-1:0] pc_q;
    logic           fetch_valid_q;

    logic           redir_any;
    logic [LEN-1:0] redir_pc;
    logic [LEN-1:0] next_pc;

    pc_btb #(
        .LEN        (LEN),
        .BTB_DEPTH  (BTB_DEPTH),
        .INST_BYTES (INST_BYTES)
    ) u_btb (
        .clk           (clk),
        .rst           (rst),
        .lookup_pc_i   (pc_q),
        .pred_taken_o  (fetch_pred_taken),
        .pred_target_o (fetch_pred_target),
        .upd_valid_i   (upd_valid && rdy_in),
        .upd_pc_i      (upd_pc),
        .upd_taken_i   (upd_taken),
        .upd_target_i  (upd_target)
    );

    // Scan from the highest channel down so the lowest asserted index wins.
    always_comb begin
        redir_any = FALSE;
        redir_pc  = '0;
        for (int i = int'(NUM_REDIRECT) - 1; i >= 0; i--) begin
            if (redirect_valid[i]) begin
                redir_any = TRUE;
                redir_pc  = redirect_pc[i*LEN +: LEN];
            end
        end
    end

    // Sequential increment wraps naturally at LEN bits.
    always_comb begin
        next_pc = fetch_pred_taken ? fetch_pred_target : pc_q + LEN'(INST_BYTES);
    end

    // Redirect beats the handshake advance in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            fetch_valid_q <= FALSE;
        end else if (rdy_in) begin
            if (redir_any) begin
                state_q       <= ST_FLUSH;
                pc_q          <= redir_pc;
                fetch_valid_q <= FALSE;
            end else begin
                case (state_q)
                    ST_BOOT, ST_FLUSH: begin
                        state_q       <= ST_RUN;
                        fetch_valid_q <= TRUE;
                    end
                    ST_RUN: begin
                        if (fetch_valid_q && fetch_ready) begin
                            pc_q <= next_pc;
                        end
                    end
                    default: begin
                        state_q       <= ST_BOOT;
                        fetch_valid_q <= FALSE;
                    end
                endcase
            end
        end
    end

    assign fetch_pc    = pc_q;
    assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_pc_gen_bp.sv
// Self-checking bench for pc_gen_bp: directed scenarios plus a randomized
// run compared against a behavioural fetch/BTB model.
module tb_pc_gen_bp;

    localparam int unsigned LEN   = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned IBY   = 4;
    localparam int unsigned NR    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy_in;
    logic [NR-1:0]     redirect_valid;
    logic [NR*LEN-1:0] redirect_pc;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [LEN-1:0]    fetch_pc;
    logic              fetch_pred_taken;
    logic [LEN-1:0]    fetch_pred_target;
    logic              upd_valid;
    logic [LEN-1:0]    upd_pc;
    logic              upd_taken;
    logic [LEN-1:0]    upd_target;

    int checks = 0;
    int errors = 0;

    pc_gen_bp #(
        .LEN          (LEN),
        .RESET_PC     (32'h0),
        .INST_BYTES   (IBY),
        .BTB_DEPTH    (DEPTH),
        .NUM_REDIRECT (NR)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy_in            (rdy_in),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .fetch_valid       (fetch_valid),
        .fetch_ready       (fetch_ready),
        .fetch_pc          (fetch_pc),
        .fetch_pred_taken  (fetch_pred_taken),
        .fetch_pred_target (fetch_pred_target),
        .upd_valid         (upd_valid),
        .upd_pc            (upd_pc),
        .upd_taken         (upd_taken),
        .upd_target        (upd_target)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 = booting, 1 = running, 2 = flushing.
    logic [31:0] m_pc;
    int          m_mode;
    bit          m_v   [DEPTH];
    logic [31:0] m_tag [DEPTH];
    logic [31:0] m_tgt [DEPTH];
    int          m_ctr [DEPTH];

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / IBY) % DEPTH);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (IBY * DEPTH);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_v[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_pred_taken();
        return m_hit(m_pc) && (m_ctr[idx_of(m_pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target();
        return m_pred_taken() ? m_tgt[idx_of(m_pc)] : 32'h0;
    endfunction

    task automatic model_reset();
        m_pc   = 32'h0;
        m_mode = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_v[i] = 1'b0; m_tag[i] = 32'h0; m_tgt[i] = 32'h0; m_ctr[i] = 1;
        end
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; redirect_valid = '0; redirect_pc = '0; fetch_ready = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    endtask

    // Advance one clock; the model consumes the inputs held during the cycle.
    task automatic cycle();
        logic [31:0] npc;
        int          nmode;
        bit          pt;
        logic [31:0] ptg;
        int          k;
        npc = m_pc; nmode = m_mode;
        pt = m_pred_taken(); ptg = m_pred_target();
        if (rdy_in) begin
            if (upd_valid) begin
                k = idx_of(upd_pc);
                if (m_hit(upd_pc)) begin
                    if (upd_taken) begin
                        m_ctr[k] = (m_ctr[k] < 3) ? m_ctr[k] + 1 : 3;
                        m_tgt[k] = upd_target;
                    end else begin
                        m_ctr[k] = (m_ctr[k] > 0) ? m_ctr[k] - 1 : 0;
                    end
                end else if (upd_taken) begin
                    m_v[k] = 1'b1; m_tag[k] = tag_of(upd_pc); m_tgt[k] = upd_target; m_ctr[k] = 2;
                end
            end
            if (redirect_valid[0]) begin
                npc = redirect_pc[31:0]; nmode = 2;
            end else if (redirect_valid[1]) begin
                npc = redirect_pc[63:32]; nmode = 2;
            end else if (m_mode == 1) begin
                if (fetch_ready) npc = pt ? ptg : m_pc + 32'd4;
            end else begin
                nmode = 1;
            end
        end
        @(posedge clk);
        m_pc = npc; m_mode = nmode;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #1;
        model_reset();
        checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", fetch_pc, 32'h0); end
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", fetch_valid); end
        checks++; if (fetch_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred got %b want 0", fetch_pred_taken); end
        checks++; if (fetch_pred_target !== 32'h0) begin errors++; $display("FAIL reset_tgt got %h want 0", fetch_pred_target); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL boot_valid got %b want 0", fetch_valid); end
        cycle();
        checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0) begin errors++; $display("FAIL boot_to_run got v=%b pc=%h want v=1 pc=0", fetch_valid, fetch_pc); end
    endtask

    task automatic test_sequential();
        fetch_ready = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            cycle();
            checks++; if (fetch_pc !== 32'(k * 4)) begin errors++; $display("FAIL seq_pc got %h want %h", fetch_pc, 32'(k * 4)); end
        end
    endtask

    task automatic test_backpressure();
        fetch_ready = 1'b0;
        repeat (3) begin
            cycle();
            checks++; if (fetch_pc !== 32'h8 || fetch_valid !== 1'b1) begin errors++; $display("FAIL bp_hold got v=%b pc=%h want v=1 pc=8", fetch_valid, fetch_pc); end
        end
        fetch_ready = 1'b1;
        cycle();
        checks++; if (fetch_pc !== 32'hC) begin errors++; $display("FAIL bp_release got %h want c", fetch_pc); end
        fetch_ready = 1'b0;
    endtask

    task automatic test_redirect_priority();
        fetch_ready = 1'b1;
        redirect_valid = 2'b11;
        redirect_pc = {32'h200, 32'h100};
        cycle();
        redirect_valid = '0;
        checks++; if (fetch_pc !== 32'h100 || fetch_valid !== 1'b0) begin errors++; $display("FAIL redir_prio got v=%b pc=%h want v=0 pc=100", fetch_valid, fetch_pc); end
        cycle();
        checks++; if (fetch_pc !== 32'h100 || fetch_valid !== 1'b1) begin errors++; $display("FAIL redir_flush got v=%b pc=%h want v=1 pc=100", fetch_valid, fetch_pc); end
        cycle();
        checks++; if (fetch_pc !== 32'h104) begin errors++; $display("FAIL redir_next got %h want 104", fetch_pc); end
        fetch_ready = 1'b0;
    endtask

    task automatic test_btb_predict();
        upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b1; upd_target = 32'h80;
        cycle();
        upd_valid = 1'b0;
        redirect_valid = 2'b10; redirect_pc = {32'h10, 32'h0};
        cycle();
        redirect_valid = '0;
        cycle();
        checks++; if (fetch_pc !== 32'h10 || fetch_pred_taken !== 1'b1 || fetch_pred_target !== 32'h80)
            begin errors++; $display("FAIL btb_alloc got pc=%h pt=%b tgt=%h want 10/1/80", fetch_pc, fetch_pred_taken, fetch_pred_target); end
        fetch_ready = 1'b1;
        cycle();
        checks++; if (fetch_pc !== 32'h80) begin errors++; $display("FAIL btb_follow got %h want 80", fetch_pc); end
        fetch_ready = 1'b0;
    endtask

    task automatic test_aliasing();
        upd_valid = 1'b1; upd_pc = 32'h10; upd_taken = 1'b0; upd_target = 32'h0;
        repeat (2) cycle();
        upd_valid = 1'b0;
        redirect_valid = 2'b01; redirect_pc = {32'h0, 32'h10};
        cycle();
        redirect_valid = '0;
        cycle();
        checks++; if (fetch_pc !== 32'h10 || fetch_pred_taken !== 1'b0 || fetch_pred_target !== 32'h0)
            begin errors++; $display("FAIL ctr_down got pc=%h pt=%b tgt=%h want 10/0/0", fetch_pc, fetch_pred_taken, fetch_pred_target); end
        upd_valid = 1'b1; upd_pc = 32'h10 + 32'(4 * DEPTH); upd_taken = 1'b1; upd_target = 32'h200;
        cycle();
        upd_valid = 1'b0;
        checks++; if (fetch_pred_taken !== 1'b0) begin errors++; $display("FAIL alias_evict got %b want 0", fetch_pred_taken); end
        redirect_valid = 2'b01; redirect_pc = {32'h0, 32'h50};
        cycle();
        redirect_valid = '0;
        cycle();
        checks++; if (fetch_pred_taken !== 1'b1 || fetch_pred_target !== 32'h200)
            begin errors++; $display("FAIL alias_alloc got pt=%b tgt=%h want 1/200", fetch_pred_taken, fetch_pred_target); end
        // Update to the entry being looked up: the lookup keeps seeing the old counter.
        upd_valid = 1'b1; upd_pc = 32'h50; upd_taken = 1'b0;
        #1;
        checks++; if (fetch_pred_taken !== 1'b1) begin errors++; $display("FAIL same_cycle_old got %b want 1", fetch_pred_taken); end
        cycle();
        upd_valid = 1'b0;
        checks++; if (fetch_pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_new got %b want 0", fetch_pred_taken); end
    endtask

    task automatic test_freeze_wrap();
        rdy_in = 1'b0; fetch_ready = 1'b1;
        redirect_valid = 2'b01; redirect_pc = {32'h0, 32'h300};
        upd_valid = 1'b1; upd_pc = 32'h50; upd_taken = 1'b1; upd_target = 32'h400;
        repeat (3) begin
            cycle();
            checks++; if (fetch_pc !== 32'h50 || fetch_valid !== 1'b1 || fetch_pred_taken !== 1'b0)
                begin errors++; $display("FAIL freeze got pc=%h v=%b pt=%b want 50/1/0", fetch_pc, fetch_valid, fetch_pred_taken); end
        end
        idle_inputs();
        redirect_valid = 2'b01; redirect_pc = {32'h0, 32'hFFFF_FFFC};
        cycle();
        redirect_valid = '0;
        cycle();
        checks++; if (fetch_pc !== 32'hFFFF_FFFC || fetch_valid !== 1'b1) begin errors++; $display("FAIL wrap_load got v=%b pc=%h want 1/fffffffc", fetch_valid, fetch_pc); end
        fetch_ready = 1'b1;
        cycle();
        checks++; if (fetch_pc !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h want 0", fetch_pc); end
        fetch_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] pool [6];
        pool = '{32'h0, 32'h10, 32'h20, 32'h50, 32'h60, 32'h90};
        return pool[$urandom_range(0, 5)];
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rdy_in         = ($urandom_range(0, 7) != 0);
            fetch_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
            redirect_pc    = {pick_pc(), pick_pc()};
            upd_valid      = ($urandom_range(0, 1) == 1);
            upd_pc         = ($urandom_range(0, 3) == 0) ? fetch_pc : pick_pc();
            upd_taken      = ($urandom_range(0, 2) != 0);
            upd_target     = 32'($urandom_range(0, 63)) * 32'd4;
            cycle();
            checks++; if (fetch_pc !== m_pc || fetch_valid !== (m_mode == 1))
                begin errors++; $display("FAIL rand_pc n=%0d got v=%b pc=%h want v=%b pc=%h", n, fetch_valid, fetch_pc, (m_mode == 1), m_pc); end
            checks++; if (fetch_pred_taken !== m_pred_taken() || fetch_pred_target !== m_pred_target())
                begin errors++; $display("FAIL rand_pred n=%0d got %b/%h want %b/%h", n, fetch_pred_taken, fetch_pred_target, m_pred_taken(), m_pred_target()); end
        end
    endtask

    task automatic test_mid_reset();
        // Ensure entry for pc 0 is allocated, then reset with work pending.
        idle_inputs();
        upd_valid = 1'b1; upd_pc = 32'h0; upd_taken = 1'b1; upd_target = 32'h44;
        cycle();
        redirect_valid = 2'b01; redirect_pc = {32'h0, 32'h20};
        upd_pc = 32'h20; upd_target = 32'h88; fetch_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checks++; if (fetch_pc !== 32'h0 || fetch_valid !== 1'b0 || fetch_pred_taken !== 1'b0)
            begin errors++; $display("FAIL mid_reset got pc=%h v=%b pt=%b want 0/0/0", fetch_pc, fetch_valid, fetch_pred_taken); end
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        cycle();
        checks++; if (fetch_pc !== 32'h0 || fetch_valid !== 1'b1 || fetch_pred_taken !== 1'b0)
            begin errors++; $display("FAIL post_reset got pc=%h v=%b pt=%b want 0/1/0", fetch_pc, fetch_valid, fetch_pred_taken); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_priority();
        test_btb_predict();
        test_aliasing();
        test_freeze_wrap();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
